// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared widths, state encoding and Booth recode constants
package booth_pkg;

    localparam int WIDTH = 8;
    localparam int STEPS = WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth recoding of the {Q[0], Q_1} pair.
    localparam logic [1:0] ENC_NOP0 = 2'b00;
    localparam logic [1:0] ENC_ADD  = 2'b01;
    localparam logic [1:0] ENC_SUB  = 2'b10;
    localparam logic [1:0] ENC_NOP1 = 2'b11;

endpackage

// File: rtl/booth_multiplier_if.sv
// rtl/booth_multiplier_if.sv - requester/multiplier handshake bundle
//
// master : requester side, drives operands and start, observes ans/ready
// slave  : multiplier side, consumes operands and start, drives ans/ready
interface booth_multiplier_if #(
    parameter int WIDTH = booth_pkg::WIDTH
);
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   r;
    logic               start;
    logic [2*WIDTH-1:0] ans;
    logic               ready;

    modport master (output m, output r, output start, input  ans, input  ready);
    modport slave  (input  m, input  r, input  start, output ans, output ready);
endinterface

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth add/sub and arithmetic shift
//
// a_i/q_i/q1_i/m_i : current accumulator, multiplier, previous LSB, multiplicand
// a_o/q_o/q1_o     : state after the add/sub and the shift of {A,Q,Q_1}
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = booth_pkg::WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = a_i;
        case ({q_i[0], q1_i})
            ENC_ADD: sum = a_i + m_i;
            ENC_SUB: sum = a_i - m_i;
            default: sum = a_i;
        endcase
        // Arithmetic shift of the concatenation {sum, Q, Q_1}: the guard bit
        // of A is replicated so M = -2^(WIDTH-1) never overflows.
        a_o  = {sum[WIDTH], sum[WIDTH:1]};
        q_o  = {sum[0], q_i[WIDTH-1:1]};
        q1_o = q_i[0];
    end

endmodule

// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - sequential radix-2 Booth signed multiplier
//
// ans   : registered signed product, 2*WIDTH bits
// m, r  : signed multiplicand / multiplier, sampled only when start is accepted
// clk   : rising-edge clock
// rst   : asynchronous active-low reset
// start : accepted in IDLE or DONE, ignored while BUSY
// ready : high while ans holds a completed product
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = booth_pkg::WIDTH
) (
    output logic [2*WIDTH-1:0] ans,
    input  logic [WIDTH-1:0]   m,
    input  logic [WIDTH-1:0]   r,
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               ready
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q1_q, q1_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] ans_q, ans_d;
    logic               ready_q, ready_d;

    logic [WIDTH:0]     a_nx;
    logic [WIDTH-1:0]   q_nx;
    logic               q1_nx;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_i  (a_q),
        .q_i  (q_q),
        .q1_i (q1_q),
        .m_i  (m_q),
        .a_o  (a_nx),
        .q_o  (q_nx),
        .q1_o (q1_nx)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        count_d = count_q;
        ans_d   = ans_q;
        ready_d = ready_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = r;
                    q1_d    = 1'b0;
                    m_d     = {m[WIDTH-1], m};
                    count_d = CNT_W'(STEPS);
                    ready_d = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d     = a_nx;
                q_d     = q_nx;
                q1_d    = q1_nx;
                count_d = count_q - 1'b1;
                // count_q == 1 means this edge performs the final step, so the
                // product is taken straight from the step outputs.
                if (count_q == CNT_W'(1)) begin
                    ans_d   = {a_nx[WIDTH-1:0], q_nx};
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            count_q <= '0;
            ans_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            count_q <= count_d;
            ans_q   <= ans_d;
            ready_q <= ready_d;
        end
    end

    assign ans   = ans_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - randomized self-checking bench for booth_multiplier
module tb_booth_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b0;

    booth_multiplier_if bus ();

    booth_multiplier dut (
        .ans   (bus.ans),
        .m     (bus.m),
        .r     (bus.r),
        .clk   (clk),
        .rst   (rst),
        .start (bus.start),
        .ready (bus.ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int pa;
        int pb;
        int p;
        pa = int'($signed(a));
        pb = int'($signed(b));
        p  = pa * pb;
        return p[15:0];
    endfunction

    // Present operands with start for exactly one rising edge; returns #1 after it.
    task automatic accept(input logic [7:0] mv, input logic [7:0] rv);
        @(negedge clk);
        bus.m     = mv;
        bus.r     = rv;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Cycles from the current point until ready, bounded at 30.
    task automatic wait_ready(output int lat);
        lat = 0;
        while (!bus.ready && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.m = '0; bus.r = '0; bus.start = 1'b0;
        rst = 1'b0;
        #6;
        checks++;
        if (bus.ans !== 16'h0000) begin errors++; $display("FAIL reset_ans: got %h want 0000", bus.ans); end
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", bus.ready); end
    endtask

    task automatic test_basic_held_start();
        int lat;
        logic [15:0] exp;
        exp = ref_mul(8'd33, 8'd20);
        @(negedge clk);
        bus.m = 8'd33; bus.r = 8'd20; bus.start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL basic_ready_low: got %b want 0", bus.ready); end
        @(posedge clk);          // second edge with start high lands in BUSY
        #1 bus.start = 1'b0;
        wait_ready(lat);
        lat = lat + 1;
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
        checks++;
        if (bus.ans !== exp) begin errors++; $display("FAIL basic_ans: got %h want %h", bus.ans, exp); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b1 || bus.ans !== exp) begin
            errors++; $display("FAIL basic_single_op: got ready=%b ans=%h want ready=1 ans=%h", bus.ready, bus.ans, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mv [2];
        logic [7:0] rv [2];
        logic [15:0] prev;
        int lat;
        mv[0] = 8'hFB; rv[0] = 8'd7;     // -5 * 7
        mv[1] = 8'd127; rv[1] = 8'h80;   // 127 * -128
        for (int i = 0; i < 2; i++) begin
            prev = bus.ans;
            accept(mv[i], rv[i]);
            checks++;
            if (bus.ready !== 1'b0 || bus.ans !== prev) begin
                errors++; $display("FAIL b2b_accept_%0d: got ready=%b ans=%h want ready=0 ans=%h", i, bus.ready, bus.ans, prev);
            end
            wait_ready(lat);
            checks++;
            if (lat !== 8) begin errors++; $display("FAIL b2b_latency_%0d: got %0d want 8", i, lat); end
            checks++;
            if (bus.ans !== ref_mul(mv[i], rv[i])) begin
                errors++; $display("FAIL b2b_ans_%0d: got %h want %h", i, bus.ans, ref_mul(mv[i], rv[i]));
            end
        end
    endtask

    task automatic test_corners();
        logic [7:0] mv [5];
        logic [7:0] rv [5];
        int lat;
        mv[0] = 8'h80; rv[0] = 8'h80;
        mv[1] = 8'h00; rv[1] = 8'hFF;
        mv[2] = 8'h7F; rv[2] = 8'h7F;
        mv[3] = 8'h80; rv[3] = 8'h7F;
        mv[4] = 8'h01; rv[4] = 8'h80;
        for (int i = 0; i < 5; i++) begin
            accept(mv[i], rv[i]);
            wait_ready(lat);
            checks++;
            if (lat !== 8 || bus.ans !== ref_mul(mv[i], rv[i])) begin
                errors++; $display("FAIL corner_%0d: got lat=%0d ans=%h want lat=8 ans=%h", i, lat, bus.ans, ref_mul(mv[i], rv[i]));
            end
        end
    endtask

    task automatic test_operand_change();
        int lat;
        accept(8'd33, 8'd20);
        lat = 0;
        while (!bus.ready && lat < 30) begin
            @(negedge clk);
            bus.m = 8'($urandom);
            bus.r = 8'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 8 || bus.ans !== ref_mul(8'd33, 8'd20)) begin
            errors++; $display("FAIL operand_change: got lat=%0d ans=%h want lat=8 ans=%h", lat, bus.ans, ref_mul(8'd33, 8'd20));
        end
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        accept(8'd100, 8'hB3);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.ans !== 16'h0000 || bus.ready !== 1'b0) begin
            errors++; $display("FAIL midbusy_reset: got ans=%h ready=%b want ans=0000 ready=0", bus.ans, bus.ready);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b0 || bus.ans !== 16'h0000) begin
            errors++; $display("FAIL midbusy_no_partial: got ans=%h ready=%b want ans=0000 ready=0", bus.ans, bus.ready);
        end
        accept(8'd3, 8'd3);
        wait_ready(lat);
        checks++;
        if (lat !== 8 || bus.ans !== 16'd9) begin
            errors++; $display("FAIL after_reset_op: got lat=%0d ans=%h want lat=8 ans=0009", lat, bus.ans);
        end
    endtask

    task automatic test_hold();
        int lat;
        int bad;
        logic [7:0] mv, rv;
        logic [15:0] exp;
        mv = 8'($urandom); rv = 8'($urandom);
        exp = ref_mul(mv, rv);
        accept(mv, rv);
        wait_ready(lat);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.ready !== 1'b1 || bus.ans !== exp) bad++;
        end
        checks++;
        if (bad !== 0 || lat !== 8) begin
            errors++; $display("FAIL hold_stable: got %0d unstable cycles lat=%0d ans=%h want 0 unstable lat=8 ans=%h", bad, lat, bus.ans, exp);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] mv, rv;
        for (int i = 0; i < 40; i++) begin
            mv = 8'($urandom); rv = 8'($urandom);
            accept(mv, rv);
            wait_ready(lat);
            checks++;
            if (lat !== 8 || bus.ans !== ref_mul(mv, rv)) begin
                errors++; $display("FAIL random_%0d: m=%h r=%h got lat=%0d ans=%h want lat=8 ans=%h", i, mv, rv, lat, bus.ans, ref_mul(mv, rv));
            end
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic_held_start();
        test_back_to_back();
        test_corners();
        test_operand_change();
        test_reset_mid_busy();
        test_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
